// File: rtl/cas_sort_seq.sv
// Block sorter: loads DEPTH words, sorts them in place with block odd-even
// transposition through one shared 4-input compare-and-swap, then streams
// the result out over a valid/ready interface.
// Build option: CAS_SORT_ASCEND_EN reverses the drain order (ascending output).

// Purely combinational 4-input sorter: a_o >= b_o >= c_o >= d_o (unsigned).
module cas4 #(
    parameter int BITS = 8
) (
    input  logic [BITS-1:0] a_i,
    input  logic [BITS-1:0] b_i,
    input  logic [BITS-1:0] c_i,
    input  logic [BITS-1:0] d_i,
    output logic [BITS-1:0] a_o,
    output logic [BITS-1:0] b_o,
    output logic [BITS-1:0] c_o,
    output logic [BITS-1:0] d_o
);
    logic [BITS-1:0] s1a, s1b, s1c, s1d;
    logic [BITS-1:0] s2a, s2b, s2c, s2d;

    // Five compare-exchange network: pairs, then extremes, then middle pair.
    always_comb begin
        s1a = (a_i >= b_i) ? a_i : b_i;
        s1b = (a_i >= b_i) ? b_i : a_i;
        s1c = (c_i >= d_i) ? c_i : d_i;
        s1d = (c_i >= d_i) ? d_i : c_i;
        s2a = (s1a >= s1c) ? s1a : s1c;
        s2c = (s1a >= s1c) ? s1c : s1a;
        s2b = (s1b >= s1d) ? s1b : s1d;
        s2d = (s1b >= s1d) ? s1d : s1b;
        a_o = s2a;
        b_o = (s2b >= s2c) ? s2b : s2c;
        c_o = (s2b >= s2c) ? s2c : s2b;
        d_o = s2d;
    end
endmodule

module cas_sort_seq #(
    parameter int BITS  = 8,
    parameter int DEPTH = 8
) (
    input  logic            clk_50,
    input  logic            rst,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [BITS-1:0] in_data,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [BITS-1:0] out_data,
    output logic            out_last,
    output logic            busy
);
    localparam int IW = $clog2(DEPTH);
    localparam int K  = DEPTH / 2;
    localparam int PW = (K > 1) ? $clog2(K) : 1;

    localparam logic [IW-1:0] LAST_IDX = IW'(DEPTH - 1);
    localparam logic [IW-1:0] EVEN_END = IW'(DEPTH - 4);
    localparam logic [IW-1:0] ODD_END  = IW'((DEPTH >= 8) ? (DEPTH - 6) : 0);
    localparam logic [PW-1:0] LAST_PH  = PW'(K - 1);
`ifdef CAS_SORT_ASCEND_EN
    localparam logic [IW-1:0] FIRST_RD = LAST_IDX;
    localparam logic [IW-1:0] FINAL_RD = '0;
`else
    localparam logic [IW-1:0] FIRST_RD = '0;
    localparam logic [IW-1:0] FINAL_RD = LAST_IDX;
`endif

    localparam logic [1:0] ST_LOAD  = 2'd0;
    localparam logic [1:0] ST_SORT  = 2'd1;
    localparam logic [1:0] ST_DRAIN = 2'd2;

    logic [1:0]      state_q, state_d;
    logic [IW-1:0]   wr_idx_q, wr_idx_d;
    logic [IW-1:0]   rd_idx_q, rd_idx_d;
    logic [IW-1:0]   base_q, base_d;
    logic [PW-1:0]   phase_q, phase_d;
    logic [BITS-1:0] out_data_q, out_data_d;
    logic [BITS-1:0] mem_q [DEPTH];
    logic [BITS-1:0] mem_d [DEPTH];
    logic            phase_end;

    logic [IW-1:0]   idx1, idx2, idx3;
    logic [BITS-1:0] new_a, new_b, new_c, new_d;

    assign idx1 = base_q + IW'(1);
    assign idx2 = base_q + IW'(2);
    assign idx3 = base_q + IW'(3);

    cas4 #(.BITS(BITS)) u_cas4 (
        .a_i (mem_q[base_q]),
        .b_i (mem_q[idx1]),
        .c_i (mem_q[idx2]),
        .d_i (mem_q[idx3]),
        .a_o (new_a),
        .b_o (new_b),
        .c_o (new_c),
        .d_o (new_d)
    );

    // Next-state: load writes, one sort window per cycle, drain read pointer.
    // On the final sort cycle the first output word is taken from mem_d so a
    // word rewritten by that last window is presented without an extra cycle.
    always_comb begin
        state_d    = state_q;
        wr_idx_d   = wr_idx_q;
        rd_idx_d   = rd_idx_q;
        base_d     = base_q;
        phase_d    = phase_q;
        out_data_d = out_data_q;
        mem_d      = mem_q;
        phase_end  = 1'b0;
        case (state_q)
            ST_LOAD: begin
                if (in_valid) begin
                    mem_d[wr_idx_q] = in_data;
                    if (wr_idx_q == LAST_IDX) begin
                        wr_idx_d = '0;
                        base_d   = '0;
                        phase_d  = '0;
                        state_d  = ST_SORT;
                    end else begin
                        wr_idx_d = wr_idx_q + IW'(1);
                    end
                end
            end
            ST_SORT: begin
                mem_d[base_q] = new_a;
                mem_d[idx1]   = new_b;
                mem_d[idx2]   = new_c;
                mem_d[idx3]   = new_d;
                phase_end = phase_q[0] ? (base_q == ODD_END) : (base_q == EVEN_END);
                if (phase_end) begin
                    // With DEPTH=4 the only odd phase has no windows.
                    if ((phase_q == LAST_PH) || (DEPTH == 4)) begin
                        state_d    = ST_DRAIN;
                        rd_idx_d   = FIRST_RD;
                        out_data_d = mem_d[FIRST_RD];
                    end else begin
                        phase_d = phase_q + PW'(1);
                        base_d  = phase_q[0] ? IW'(0) : IW'(2);
                    end
                end else begin
                    base_d = base_q + IW'(4);
                end
            end
            ST_DRAIN: begin
                if (out_ready) begin
                    if (rd_idx_q == FINAL_RD) begin
                        state_d  = ST_LOAD;
                        rd_idx_d = '0;
                        wr_idx_d = '0;
                    end else begin
`ifdef CAS_SORT_ASCEND_EN
                        rd_idx_d = rd_idx_q - IW'(1);
`else
                        rd_idx_d = rd_idx_q + IW'(1);
`endif
                        out_data_d = mem_q[rd_idx_d];
                    end
                end
            end
            default: state_d = ST_LOAD;
        endcase
    end

    // Control and output registers, cleared by asynchronous reset.
    always_ff @(posedge clk_50 or posedge rst) begin
        if (rst) begin
            state_q    <= ST_LOAD;
            wr_idx_q   <= '0;
            rd_idx_q   <= '0;
            base_q     <= '0;
            phase_q    <= '0;
            out_data_q <= '0;
        end else begin
            state_q    <= state_d;
            wr_idx_q   <= wr_idx_d;
            rd_idx_q   <= rd_idx_d;
            base_q     <= base_d;
            phase_q    <= phase_d;
            out_data_q <= out_data_d;
        end
    end

    // Word storage; contents are don't-care after reset.
    always_ff @(posedge clk_50) begin
        mem_q <= mem_d;
    end

    assign in_ready  = (state_q == ST_LOAD);
    assign out_valid = (state_q == ST_DRAIN);
    assign busy      = (state_q == ST_SORT) || (state_q == ST_DRAIN);
    assign out_data  = out_data_q;
    assign out_last  = out_valid && (rd_idx_q == FINAL_RD);
endmodule

// File: tb/tb_cas_sort_seq.sv
// Self-checking bench for cas_sort_seq (DEPTH=8). A queue-based model predicts
// handshakes and the sorted output stream; directed jobs pin the model.
module tb_cas_sort_seq;
    localparam int DEPTH = 8;
    localparam int S     = (DEPTH / 4) * (DEPTH / 2 - 1);

    typedef logic [7:0] word_t;
    typedef word_t wq_t[$];

    logic       clk_50 = 1'b0;
    logic       rst;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] in_data;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] out_data;
    logic       out_last;
    logic       busy;

    int total = 0;
    int bad   = 0;

    cas_sort_seq #(.BITS(8), .DEPTH(DEPTH)) dut (
        .clk_50    (clk_50),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_last  (out_last),
        .busy      (busy)
    );

    always #5 clk_50 = ~clk_50;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d want %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic timeout_fail(input string name);
        total++;
        bad++;
        $display("FAIL %s: timed out (t=%0t)", name, $time);
    endtask

    // ---------------- model ----------------
    wq_t in_buf;
    wq_t out_q;
    int  sort_left = 0;

    function automatic wq_t sort_model(input wq_t q);
        wq_t r;
        int  pos;
        foreach (q[i]) begin
            pos = r.size();
            for (int j = 0; j < r.size(); j++) begin
`ifdef CAS_SORT_ASCEND_EN
                if (r[j] > q[i]) begin pos = j; break; end
`else
                if (r[j] < q[i]) begin pos = j; break; end
`endif
            end
            r.insert(pos, q[i]);
        end
        return r;
    endfunction

    function automatic bit m_rdy();
        return (sort_left == 0) && (out_q.size() == 0);
    endfunction

    function automatic bit m_valid();
        return (sort_left == 0) && (out_q.size() != 0);
    endfunction

    initial begin
        forever begin
            @(posedge clk_50);
            if (rst) begin
                in_buf.delete();
                out_q.delete();
                sort_left = 0;
            end else if (m_rdy() && in_valid) begin
                in_buf.push_back(in_data);
                if (in_buf.size() == DEPTH) begin
                    out_q = sort_model(in_buf);
                    in_buf.delete();
                    sort_left = S;
                end
            end else if (sort_left > 0) begin
                sort_left--;
            end else if (out_q.size() != 0 && out_ready) begin
                void'(out_q.pop_front());
            end
        end
    end

    // Per-cycle comparison against the model.
    initial begin
        forever begin
            @(negedge clk_50);
            if (!rst) begin
                chk("in_ready", in_ready, m_rdy());
                chk("busy", busy, !m_rdy());
                chk("out_valid", out_valid, m_valid());
                if (m_valid()) begin
                    chk("out_data", out_data, out_q[0]);
                    chk("out_last", out_last, out_q.size() == 1);
                end
            end
        end
    end

    // out_ready pattern generator.
    int rmode = 0;
    int rcyc  = 0;
    initial begin
        out_ready = 1'b1;
        forever begin
            @(negedge clk_50);
            rcyc++;
            case (rmode)
                1:       out_ready = (rcyc % 2) == 0;
                2:       out_ready = ((rcyc % 16) < 5) ? 1'b0 : ((rcyc % 2) == 0);
                3:       out_ready = ($urandom_range(3) != 0);
                default: out_ready = 1'b1;
            endcase
        end
    end

    // ---------------- stimulus ----------------
    task automatic push(input word_t d, input int gap);
        int g = 0;
        in_valid = 1'b1;
        in_data  = d;
        while (!m_rdy() && g < 300) begin
            @(negedge clk_50);
            g++;
        end
        if (g >= 300) timeout_fail("push");
        @(negedge clk_50);
        in_valid = 1'b0;
        repeat (gap) @(negedge clk_50);
    endtask

    task automatic wait_idle();
        int g = 0;
        while (!(m_rdy() && in_buf.size() == 0) && g < 500) begin
            @(negedge clk_50);
            g++;
        end
        if (g >= 500) timeout_fail("wait_idle");
    endtask

    task automatic rand_job(input int maxgap);
        for (int i = 0; i < DEPTH; i++) push(word_t'($urandom), $urandom_range(maxgap));
    endtask

    word_t fx_in  [8] = '{8'd3, 8'd200, 8'd17, 8'd17, 8'd0, 8'd255, 8'd90, 8'd1};
`ifdef CAS_SORT_ASCEND_EN
    word_t fx_out [8] = '{8'd0, 8'd1, 8'd3, 8'd17, 8'd17, 8'd90, 8'd200, 8'd255};
`else
    word_t fx_out [8] = '{8'd255, 8'd200, 8'd90, 8'd17, 8'd17, 8'd3, 8'd1, 8'd0};
`endif

    initial begin
        int    g;
        int    bcnt;
        word_t got [8];
        logic  lst [8];

        rst      = 1'b1;
        in_valid = 1'b0;
        in_data  = '0;
        repeat (3) @(negedge clk_50);
        #2 rst = 1'b0;
        #1;
        chk("rst_in_ready", in_ready, 1);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_out_data", out_data, 0);
        chk("rst_out_last", out_last, 0);
        @(negedge clk_50);

        // Fixed job with literal expectations.
        for (int i = 0; i < 8; i++) push(fx_in[i], 0);
        chk("model_first", out_q[0], fx_out[0]);
        chk("model_last", out_q[7], fx_out[7]);
        bcnt = 0;
        g    = 0;
        while (!out_valid && g < 50) begin
            if (busy) bcnt++;
            @(negedge clk_50);
            g++;
        end
        chk("sort_cycles", bcnt, 6);
        for (int i = 0; i < 8; i++) begin
            g = 0;
            while (!(out_valid && out_ready) && g < 50) begin
                @(negedge clk_50);
                g++;
            end
            if (g >= 50) timeout_fail("fixed_out");
            got[i] = out_data;
            lst[i] = out_last;
            @(negedge clk_50);
        end
        for (int i = 0; i < 8; i++) begin
            chk($sformatf("fixed_data%0d", i), got[i], fx_out[i]);
            chk($sformatf("fixed_last%0d", i), lst[i], (i == 7) ? 1 : 0);
        end
        wait_idle();

        // Backpressure: alternating ready, then alternating with low bursts.
        rmode = 1;
        rand_job(0);
        wait_idle();
        rmode = 2;
        rand_job(0);
        rand_job(0);
        wait_idle();
        rmode = 0;

        // Input gaps, then in_valid held high through SORT and DRAIN.
        for (int i = 0; i < DEPTH; i++) push(fx_in[i], 3);
        in_valid = 1'b1;
        in_data  = 8'hEE;
        g = 0;
        @(negedge clk_50);
        while (!m_rdy() && g < 100) begin
            @(negedge clk_50);
            g++;
        end
        if (g >= 100) timeout_fail("hold_valid");
        @(negedge clk_50);
        for (int i = 1; i < DEPTH; i++) push(word_t'(i * 13), 0);
        wait_idle();

        // Reset in the middle of SORT, then a fresh job.
        rand_job(0);
        repeat (2) @(negedge clk_50);
        #2 rst = 1'b1;
        #1;
        chk("midrst_in_ready", in_ready, 1);
        chk("midrst_out_valid", out_valid, 0);
        chk("midrst_busy", busy, 0);
        @(negedge clk_50);
        @(negedge clk_50);
        #2 rst = 1'b0;
        @(negedge clk_50);
        rand_job(0);
        wait_idle();

        // Random jobs with random backpressure and input gaps.
        rmode = 3;
        for (int j = 0; j < 1000; j++) rand_job(1);
        wait_idle();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation did not complete");
        $display("test done: total=%0d bad=%0d", total, bad + 1);
        $fatal(1);
    end
endmodule
